// File: rtl/reg_check_monitor.sv
// Register-file writeback monitor: shadows up to NUM_CHECKS architectural registers
// and issues a registered pass/fail verdict on halt or on a RUN-cycle timeout.

module reg_check_lane #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            arm_i,
  input  logic            run_i,
  input  logic            en_i,
  input  logic [4:0]      addr_i,
  input  logic [XLEN-1:0] value_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            mis_o
);
  logic            en_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] value_q, shadow_q, shadow_d;
  logic            hit;

  // x0 is never shadowed, so a channel watching x0 keeps comparing against 0
  assign hit      = run_i & wb_en_i & (wb_addr_i != 5'd0) & (wb_addr_i == addr_q);
  assign shadow_d = hit ? wb_data_i : shadow_q;
  // compare the bypassed value so a write on the halt cycle is included
  assign mis_o    = en_q & (shadow_d != value_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      addr_q   <= '0;
      value_q  <= '0;
      shadow_q <= '0;
    end else if (arm_i) begin
      en_q     <= en_i;
      addr_q   <= addr_i;
      value_q  <= value_i;
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
endmodule

module reg_check_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       halt,
  input  logic                       wb_en,
  input  logic [4:0]                 wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [NUM_CHECKS-1:0]      chk_en,
  input  logic [5*NUM_CHECKS-1:0]    chk_addr,
  input  logic [XLEN*NUM_CHECKS-1:0] chk_value,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [NUM_CHECKS-1:0]      fail_mask,
  output logic                       timeout,
  output logic [CNT_W-1:0]           cycle_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   arm, decide, running, to_hit, to_d;
  logic [NUM_CHECKS-1:0]  mis, fail_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pass_q, to_q;

  assign running = (state_q == S_RUN);
  assign to_hit  = running & (count_q >= TO_LAST);
  assign to_d    = to_hit & ~halt;
  assign count_d = (&count_q) ? count_q : count_q + CNT_W'(1);

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_lane
    reg_check_lane #(.XLEN(XLEN)) u_lane (
      .clk_i     (clk),
      .rst_i     (rst),
      .arm_i     (arm),
      .run_i     (running),
      .en_i      (chk_en[i]),
      .addr_i    (chk_addr[5*i +: 5]),
      .value_i   (chk_value[XLEN*i +: XLEN]),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .mis_o     (mis[i])
    );
  end

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    decide  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        arm     = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (halt || to_hit) begin
        decide  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        count_q <= '0;
        pass_q  <= 1'b0;
        fail_q  <= '0;
        to_q    <= 1'b0;
      end else if (running) begin
        count_q <= count_d;
      end
      if (decide) begin
        fail_q <= mis;
        to_q   <= to_d;
        pass_q <= ~to_d & ~(|mis);
      end
    end
  end

  assign busy        = running;
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign fail_mask   = fail_q;
  assign timeout     = to_q;
  assign cycle_count = count_q;
endmodule
